i2c_slave_ctrl: RTL and testbench

Parametrised I2C target controller: the next generation of the team's I2C slave. Adds a configurable input glitch filter, an address match mask, repeated-START handling, valid/ready byte handshakes on both directions, and clock stretching whenever the user side is not ready. Sits between the open-drain pad cells (SCL/SDA) and a user register file or FIFO.

---
 rtl/i2c_pkg.sv | 23 ++
 rtl/i2c_glitch_filter.sv | 44 ++++
 rtl/i2c_slave_ctrl.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_i2c_slave_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target controller.
package i2c_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      RX,
      RX_ACK,
      TX,
      TX_ACK
   } state_t;

   localparam logic [6:0] GEN_CALL_ADDR = 7'h00;

   // Masked address compare: mask bits set to 1 are ignored.
   function automatic logic addr_match(input logic [6:0] addr,
                                       input logic [6:0] own,
                                       input logic [6:0] mask);
      return ((addr ^ own) & ~mask) == 7'd0;
   endfunction

endpackage

// File: rtl/i2c_glitch_filter.sv
// Pad input conditioning: synchroniser chain followed by a stable-level filter.
// The output level follows the synchronised input only after it has held a
// new value for FILT_LEN consecutive clocks; shorter pulses are swallowed.
module i2c_glitch_filter #(
   parameter int SYNC_STAGES = 2,
   parameter int FILT_LEN    = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [3:0]             stable_cnt;
   logic                   sync_lvl;

   assign sync_lvl = sync_q[SYNC_STAGES-1];

   // Bring the raw pad into the clock domain; an idle bus reads high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      end
   end

   // Count how long the synchronised level has disagreed with the output.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dout       <= 1'b1;
         stable_cnt <= '0;
      end else if (sync_lvl == dout) begin
         stable_cnt <= '0;
      end else if (stable_cnt == 4'(FILT_LEN - 1)) begin
         dout       <= sync_lvl;
         stable_cnt <= '0;
      end else begin
         stable_cnt <= stable_cnt + 4'd1;
      end
   end

endmodule

// File: rtl/i2c_slave_ctrl.sv
// I2C target controller with glitch filtering, masked address match,
// repeated-START support, valid/ready byte handshakes and clock stretching.
// Optional feature macro: I2C_SLAVE_GEN_CALL_EN (general call address 0x00
// with write is acknowledged and flagged on the gen_call output).
module i2c_slave_ctrl
   import i2c_pkg::*;
#(
   parameter int FILT_LEN    = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       scl_i,
   input  logic       sda_i,
   output logic       scl_o,
   output logic       sda_o,
   input  logic       en,
   input  logic [6:0] own_addr,
   input  logic [6:0] addr_mask,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       rw,
   output logic       busy,
   output logic       sta,
   output logic       sto,
   output logic       nack
`ifdef I2C_SLAVE_GEN_CALL_EN
   ,
   output logic       gen_call
`endif
);

   logic       scl_f, sda_f;
   logic       scl_d, sda_d;
   logic       scl_rise, scl_fall;
   logic       start_c, stop_c;
   logic       addr_hit;
   state_t     state;
   logic [7:0] sr;
   logic [3:0] bit_cnt;
   logic       tx_loaded;
   logic       ack_n;

   i2c_glitch_filter #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_LEN    (FILT_LEN)
   ) u_scl_filt (
      .clk  (clk),
      .rst  (rst),
      .din  (scl_i),
      .dout (scl_f)
   );

   i2c_glitch_filter #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_LEN    (FILT_LEN)
   ) u_sda_filt (
      .clk  (clk),
      .rst  (rst),
      .din  (sda_i),
      .dout (sda_f)
   );

   assign scl_rise = scl_f & ~scl_d;
   assign scl_fall = ~scl_f & scl_d;
   assign start_c  = ~sda_f & sda_d & scl_f;
   assign stop_c   = sda_f & ~sda_d & scl_f;

`ifdef I2C_SLAVE_GEN_CALL_EN
   logic gc_hit;
   assign gc_hit   = (sr == {GEN_CALL_ADDR, 1'b0});
   assign addr_hit = addr_match(sr[7:1], own_addr, addr_mask) | gc_hit;
`else
   assign addr_hit = addr_match(sr[7:1], own_addr, addr_mask);
`endif

   // Previous filtered levels, used to find SCL/SDA edges.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scl_d <= 1'b1;
         sda_d <= 1'b1;
      end else begin
         scl_d <= scl_f;
         sda_d <= sda_f;
      end
   end

   // Protocol state machine; every output is a register updated here.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         scl_o     <= 1'b1;
         sda_o     <= 1'b1;
         tx_ready  <= 1'b0;
         rx_data   <= 8'h00;
         rx_valid  <= 1'b0;
         rw        <= 1'b0;
         busy      <= 1'b0;
         sta       <= 1'b0;
         sto       <= 1'b0;
         nack      <= 1'b0;
         sr        <= 8'h00;
         bit_cnt   <= 4'd0;
         tx_loaded <= 1'b0;
         ack_n     <= 1'b1;
`ifdef I2C_SLAVE_GEN_CALL_EN
         gen_call  <= 1'b0;
`endif
      end else begin
         sta      <= 1'b0;
         sto      <= 1'b0;
         nack     <= 1'b0;
         tx_ready <= 1'b0;
         if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end

         if (!en) begin
            state <= IDLE;
            scl_o <= 1'b1;
            sda_o <= 1'b1;
            busy  <= 1'b0;
         end else if (stop_c) begin
            sto   <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
            scl_o <= 1'b1;
            sda_o <= 1'b1;
`ifdef I2C_SLAVE_GEN_CALL_EN
            gen_call <= 1'b0;
`endif
         end else if (start_c) begin
            sta     <= 1'b1;
            busy    <= 1'b1;
            state   <= ADDR;
            bit_cnt <= 4'd0;
            scl_o   <= 1'b1;
            sda_o   <= 1'b1;
         end else begin
            case (state)
               IDLE: begin
                  scl_o <= 1'b1;
                  sda_o <= 1'b1;
               end

               ADDR: begin
                  if (scl_rise && bit_cnt != 4'd8) begin
                     sr      <= {sr[6:0], sda_f};
                     bit_cnt <= bit_cnt + 4'd1;
                  end
                  if (scl_fall && bit_cnt == 4'd8) begin
                     bit_cnt <= 4'd0;
                     if (addr_hit) begin
                        rw    <= sr[0];
                        sda_o <= 1'b0;
                        state <= ADDR_ACK;
`ifdef I2C_SLAVE_GEN_CALL_EN
                        if (gc_hit) begin
                           gen_call <= 1'b1;
                        end
`endif
                     end else begin
                        state <= IDLE;
                     end
                  end
               end

               ADDR_ACK: begin
                  if (scl_fall) begin
                     bit_cnt <= 4'd0;
                     if (rw) begin
                        state <= TX;
                        if (tx_valid) begin
                           sr        <= tx_data;
                           sda_o     <= tx_data[7];
                           tx_ready  <= 1'b1;
                           tx_loaded <= 1'b1;
                        end else begin
                           sda_o     <= 1'b1;
                           scl_o     <= 1'b0;
                           tx_loaded <= 1'b0;
                        end
                     end else begin
                        state <= RX;
                        sda_o <= 1'b1;
                     end
                  end
               end

               RX: begin
                  if (scl_rise && bit_cnt != 4'd8) begin
                     sr      <= {sr[6:0], sda_f};
                     bit_cnt <= bit_cnt + 4'd1;
                  end
                  if (bit_cnt == 4'd8 && (scl_fall || !scl_o)) begin
                     if (!rx_valid || rx_ready) begin
                        rx_data  <= sr;
                        rx_valid <= 1'b1;
                        sda_o    <= 1'b0;
                        bit_cnt  <= 4'd0;
                        state    <= RX_ACK;
                     end else begin
                        scl_o <= 1'b0;
                     end
                  end
               end

               RX_ACK: begin
                  if (!scl_o) begin
                     scl_o <= 1'b1;
                  end
                  if (scl_fall) begin
                     sda_o <= 1'b1;
                     state <= RX;
                  end
               end

               TX: begin
                  if (!tx_loaded) begin
                     if (tx_valid) begin
                        sr        <= tx_data;
                        sda_o     <= tx_data[7];
                        tx_ready  <= 1'b1;
                        tx_loaded <= 1'b1;
                     end
                  end else begin
                     if (tx_ready) begin
                        scl_o <= 1'b1;
                     end
                     if (scl_fall) begin
                        if (bit_cnt == 4'd7) begin
                           bit_cnt <= 4'd0;
                           sda_o   <= 1'b1;
                           state   <= TX_ACK;
                        end else begin
                           sr      <= {sr[6:0], 1'b0};
                           sda_o   <= sr[6];
                           bit_cnt <= bit_cnt + 4'd1;
                        end
                     end
                  end
               end

               TX_ACK: begin
                  if (scl_rise) begin
                     ack_n <= sda_f;
                  end
                  if (scl_fall) begin
                     bit_cnt <= 4'd0;
                     if (!ack_n) begin
                        state <= TX;
                        if (tx_valid) begin
                           sr        <= tx_data;
                           sda_o     <= tx_data[7];
                           tx_ready  <= 1'b1;
                           tx_loaded <= 1'b1;
                        end else begin
                           sda_o     <= 1'b1;
                           scl_o     <= 1'b0;
                           tx_loaded <= 1'b0;
                        end
                     end else begin
                        nack  <= 1'b1;
                        state <= IDLE;
                     end
                  end
               end

               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// Testbench for i2c_slave_ctrl: bit-level I2C master model on an open-drain
// bus, table of address-match vectors plus directed multi-cycle sequences.
module tb_i2c_slave_ctrl;
   import i2c_pkg::*;

   localparam int FILT = 4;
   localparam int Q    = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic       scl_m, sda_m;
   logic       scl_pad, sda_pad;
   logic       scl_o, sda_o;
   logic       en;
   logic [6:0] own_addr, addr_mask;
   logic [7:0] tx_data;
   logic       tx_valid, tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid, rx_ready;
   logic       rw, busy, sta, sto, nack;
`ifdef I2C_SLAVE_GEN_CALL_EN
   logic       gen_call;
`endif

   int checks = 0;
   int errors = 0;
   int sta_cnt = 0, sto_cnt = 0, nack_cnt = 0, stretch_cnt = 0;
   logic [7:0] rx_log [$];

   typedef struct {
      logic [6:0] own;
      logic [6:0] mask;
      logic [6:0] addr;
      logic       rwb;
      logic       exp_ack;
      state_t     exp_state;
   } vec_t;

   vec_t vecs [8];

   assign scl_pad = scl_m & scl_o;
   assign sda_pad = sda_m & sda_o;

   always #5 clk = ~clk;

   i2c_slave_ctrl #(.FILT_LEN(FILT), .SYNC_STAGES(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .scl_i     (scl_pad),
      .sda_i     (sda_pad),
      .scl_o     (scl_o),
      .sda_o     (sda_o),
      .en        (en),
      .own_addr  (own_addr),
      .addr_mask (addr_mask),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .rw        (rw),
      .busy      (busy),
      .sta       (sta),
      .sto       (sto),
      .nack      (nack)
`ifdef I2C_SLAVE_GEN_CALL_EN
      ,
      .gen_call  (gen_call)
`endif
   );

   // Count pulses, consumed receive bytes and stretched cycles.
   always @(posedge clk) begin
      if (sta) sta_cnt++;
      if (sto) sto_cnt++;
      if (nack) nack_cnt++;
      if (!scl_o) stretch_cnt++;
      if (rx_valid && rx_ready) rx_log.push_back(rx_data);
   end

   task automatic waitClk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic sclHigh();
      int t;
      t = 0;
      scl_m = 1'b1;
      waitClk(1);
      while (!scl_pad && t < 2000) begin
         waitClk(1);
         t++;
      end
      if (!scl_pad) begin
         checks++;
         errors++;
         $display("[TB] FAIL scl_release_timeout: got 0 expected 1");
      end
   endtask

   task automatic busStart();
      sda_m = 1'b1; waitClk(Q);
      sclHigh();    waitClk(Q);
      sda_m = 1'b0; waitClk(Q);
      scl_m = 1'b0; waitClk(Q);
   endtask

   task automatic busStop();
      sda_m = 1'b0; waitClk(Q);
      sclHigh();    waitClk(Q);
      sda_m = 1'b1; waitClk(Q);
   endtask

   task automatic writeBit(input logic b);
      sda_m = b;    waitClk(Q);
      sclHigh();    waitClk(Q);
      scl_m = 1'b0; waitClk(Q);
   endtask

   task automatic readBit(output logic b);
      sda_m = 1'b1; waitClk(Q);
      sclHigh();    waitClk(Q / 2);
      b = sda_pad;  waitClk(Q / 2);
      scl_m = 1'b0; waitClk(Q);
   endtask

   task automatic writeByte(input logic [7:0] d, output logic ackb);
      for (int i = 7; i >= 0; i--) writeBit(d[i]);
      readBit(ackb);
   endtask

   task automatic readByte(input logic master_nack, output logic [7:0] d);
      logic b;
      for (int i = 7; i >= 0; i--) begin
         readBit(b);
         d[i] = b;
      end
      writeBit(master_nack);
   endtask

   // Run one address vector: START, address byte, ACK sample, then STOP.
   task automatic applyStimulus(input vec_t v, input int idx);
      logic ackb;
      int   sto_before;
      own_addr  = v.own;
      addr_mask = v.mask;
      busStart();
      writeByte({v.addr, v.rwb}, ackb);
      checkOutput($sformatf("vec%0d_ack", idx), ackb, !v.exp_ack);
      checkOutput($sformatf("vec%0d_state", idx), 32'(dut.state), 32'(v.exp_state));
      if (v.exp_ack) checkOutput($sformatf("vec%0d_rw", idx), rw, v.rwb);
      sto_before = sto_cnt;
      busStop();
      waitClk(4);
      checkOutput($sformatf("vec%0d_sto", idx), sto_cnt, sto_before + 1);
   endtask

   initial begin
      logic       ackb;
      logic [7:0] rd;
      int         base_sta, base_sto, base_nack, base_str, hi_cnt, t;

      vecs[0] = '{7'h50, 7'h00, 7'h50, 1'b0, 1'b1, RX};
      vecs[1] = '{7'h50, 7'h00, 7'h51, 1'b0, 1'b0, IDLE};
      vecs[2] = '{7'h50, 7'h01, 7'h51, 1'b0, 1'b1, RX};
      vecs[3] = '{7'h50, 7'h0F, 7'h5A, 1'b1, 1'b1, TX};
      vecs[4] = '{7'h50, 7'h0F, 7'h70, 1'b0, 1'b0, IDLE};
`ifdef I2C_SLAVE_GEN_CALL_EN
      vecs[5] = '{7'h50, 7'h00, 7'h00, 1'b0, 1'b1, RX};
`else
      vecs[5] = '{7'h50, 7'h00, 7'h00, 1'b0, 1'b0, IDLE};
`endif
      vecs[6] = '{7'h7F, 7'h7F, 7'h12, 1'b1, 1'b1, TX};
      vecs[7] = '{7'h2A, 7'h00, 7'h2A, 1'b1, 1'b1, TX};

      rst = 1'b1; en = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
      own_addr = 7'h50; addr_mask = 7'h00;
      tx_data = 8'hFF; tx_valid = 1'b1; rx_ready = 1'b1;
      waitClk(5);
      checkOutput("rst_scl_o", scl_o, 1'b1);
      checkOutput("rst_sda_o", sda_o, 1'b1);
      checkOutput("rst_rx_valid", rx_valid, 1'b0);
      checkOutput("rst_busy", busy, 1'b0);
      checkOutput("rst_state", 32'(dut.state), 32'(IDLE));
      rst = 1'b0;
      waitClk(10);

      for (int i = 0; i < 8; i++) applyStimulus(vecs[i], i);

      // Plain write of two data bytes with the consumer always ready.
      own_addr = 7'h50; addr_mask = 7'h00; tx_valid = 1'b0;
      rx_log.delete();
      base_str = stretch_cnt; base_sto = sto_cnt;
      busStart();
      writeByte(8'hA0, ackb); checkOutput("wr_addr_ack", ackb, 1'b0);
      writeByte(8'hA5, ackb); checkOutput("wr_b0_ack", ackb, 1'b0);
      writeByte(8'h3C, ackb); checkOutput("wr_b1_ack", ackb, 1'b0);
      busStop();
      waitClk(4);
      checkOutput("wr_rx_count", rx_log.size(), 2);
      checkOutput("wr_rx0", rx_log.size() > 0 ? rx_log[0] : 8'hXX, 8'hA5);
      checkOutput("wr_rx1", rx_log.size() > 1 ? rx_log[1] : 8'hXX, 8'h3C);
      checkOutput("wr_no_stretch", stretch_cnt, base_str);
      checkOutput("wr_sto", sto_cnt, base_sto + 1);
      checkOutput("wr_busy", busy, 1'b0);

      // Read with the source not ready: SCL held low until tx_valid.
      base_nack = nack_cnt;
      busStart();
      writeByte(8'hA1, ackb); checkOutput("rd_addr_ack", ackb, 1'b0);
      hi_cnt = 0;
      for (int i = 0; i < 200; i++) begin
         waitClk(1);
         if (scl_o) hi_cnt++;
      end
      checkOutput("rd_stretch_held", hi_cnt, 0);
      checkOutput("rd_state_tx", 32'(dut.state), 32'(TX));
      tx_data = 8'h96; tx_valid = 1'b1;
      t = 0;
      while (!tx_ready && t < 50) begin waitClk(1); t++; end
      checkOutput("rd_tx_ready", tx_ready, 1'b1);
      tx_valid = 1'b0;
      waitClk(2);
      checkOutput("rd_scl_released", scl_o, 1'b1);
      readByte(1'b1, rd);
      checkOutput("rd_data", rd, 8'h96);
      checkOutput("rd_nack_pulse", nack_cnt, base_nack + 1);
      checkOutput("rd_state_idle", 32'(dut.state), 32'(IDLE));
      busStop();

      // Second byte arrives while the first is still unread.
      rx_ready = 1'b0; rx_log.delete();
      busStart();
      writeByte(8'hA0, ackb); checkOutput("st_addr_ack", ackb, 1'b0);
      writeByte(8'h11, ackb); checkOutput("st_b0_ack", ackb, 1'b0);
      checkOutput("st_rx_data0", rx_data, 8'h11);
      for (int i = 7; i >= 0; i--) writeBit(1'(8'h22 >> i));
      waitClk(30);
      checkOutput("st_scl_low", scl_o, 1'b0);
      checkOutput("st_rx_hold", rx_data, 8'h11);
      rx_ready = 1'b1; waitClk(1); rx_ready = 1'b0;
      waitClk(3);
      checkOutput("st_rx_data1", rx_data, 8'h22);
      checkOutput("st_rx_valid", rx_valid, 1'b1);
      checkOutput("st_scl_rel", scl_o, 1'b1);
      checkOutput("st_ack_drive", sda_o, 1'b0);
      readBit(ackb); checkOutput("st_b1_ack", ackb, 1'b0);
      rx_ready = 1'b1; waitClk(3);
      checkOutput("st_log_count", rx_log.size(), 2);
      checkOutput("st_log0", rx_log.size() > 0 ? rx_log[0] : 8'hXX, 8'h11);
      checkOutput("st_rx_valid_clr", rx_valid, 1'b0);
      busStop();

      // SDA pulses with SCL high: one clock short of the filter, then exact.
      waitClk(10);
      base_sta = sta_cnt; base_sto = sto_cnt;
      sda_m = 1'b0; waitClk(FILT - 1); sda_m = 1'b1; waitClk(30);
      checkOutput("spike_no_sta", sta_cnt, base_sta);
      checkOutput("spike_no_sto", sto_cnt, base_sto);
      sda_m = 1'b0; waitClk(FILT); sda_m = 1'b1; waitClk(30);
      checkOutput("pulse_sta", sta_cnt, base_sta + 1);
      checkOutput("pulse_sto", sto_cnt, base_sto + 1);

      // Repeated START in the middle of a received byte.
      busStart();
      writeByte(8'hA0, ackb); checkOutput("rs_addr_ack", ackb, 1'b0);
      writeBit(1'b1); writeBit(1'b0); writeBit(1'b1);
      checkOutput("rs_state_rx", 32'(dut.state), 32'(RX));
      base_sta = sta_cnt;
      busStart();
      checkOutput("rs_sta", sta_cnt, base_sta + 1);
      checkOutput("rs_state_addr", 32'(dut.state), 32'(ADDR));
      checkOutput("rs_busy", busy, 1'b1);
      writeByte(8'hA0, ackb); checkOutput("rs_readdr_ack", ackb, 1'b0);
      busStop();

      // Asynchronous reset while waiting for the master's ACK on a read.
      tx_data = 8'h5A; tx_valid = 1'b1;
      busStart();
      writeByte(8'hA1, ackb); checkOutput("ra_addr_ack", ackb, 1'b0);
      for (int i = 7; i >= 0; i--) begin
         readBit(ackb);
         rd[i] = ackb;
      end
      checkOutput("ra_data", rd, 8'h5A);
      checkOutput("ra_state", 32'(dut.state), 32'(TX_ACK));
      #3 rst = 1'b1;
      #1;
      checkOutput("ra_scl_o", scl_o, 1'b1);
      checkOutput("ra_sda_o", sda_o, 1'b1);
      checkOutput("ra_rw", rw, 1'b0);
      checkOutput("ra_busy", busy, 1'b0);
      checkOutput("ra_rx_data", rx_data, 8'h00);
      checkOutput("ra_tx_ready", tx_ready, 1'b0);
      checkOutput("ra_state_idle", 32'(dut.state), 32'(IDLE));
      waitClk(3);
      rst = 1'b0; tx_valid = 1'b0;
      scl_m = 1'b1; sda_m = 1'b1;
      waitClk(20);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
